stripe_feeder: RTL

- Upstream sequencer for PE_array_64. Buffers the reference gene B and the query gene A (1024 bases each, 2-bit encoded).
- For each of 16 stripes it presents 64 B bases in parallel and streams A one base per cycle, starting from the accumulated start position.
- Captures per-stripe results, then waits out the array's trace-back phase before reporting done.

---
 rtl/feeder_pkg.sv | 36 +++
 rtl/gene_buffer.sv | 31 +++
 rtl/stripe_feeder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/feeder_pkg.sv
// Shared types and constants for the stripe feeder: base encoding, positions,
// FSM states and the fixed geometry of the 64-PE array.
package feeder_pkg;

    localparam int N_PE      = 64;
    localparam int SEQ_LEN   = 1024;
    localparam int N_STRIPE  = SEQ_LEN / N_PE;
    localparam int SCORE_W   = 14;
    localparam int DRAIN_MAX = 1024;

    localparam int ADDR_W   = 10;
    localparam int ABS_W    = 11;
    localparam int STRIPE_W = 4;
    localparam int PTR_W    = 12;
    localparam int ROW_W    = 2 * N_PE;

    typedef logic [1:0]          base_t;
    typedef logic [ADDR_W-1:0]   rel_pos_t;
    typedef logic [ABS_W-1:0]    abs_pos_t;
    typedef logic [STRIPE_W-1:0] stripe_t;
    typedef logic [PTR_W-1:0]    ptr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STREAM,
        S_TRACE_WAIT_LO,
        S_TRACE_WAIT_HI
    } state_t;

    // Pointer wide enough for a saturated start (2047) plus the full drain window.
    localparam ptr_t    SEQ_END     = ptr_t'(SEQ_LEN);
    localparam ptr_t    WDOG_LIMIT  = ptr_t'(SEQ_LEN + DRAIN_MAX);
    localparam stripe_t LAST_STRIPE = stripe_t'(N_STRIPE - 1);

endpackage

// File: rtl/gene_buffer.sv
// Storage for both genes: A read one base at a time, B read one 64-base row
// at a time. A single write port serves both, steered by wr_sel.
module gene_buffer
    import feeder_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  rel_pos_t         wr_addr,
    input  base_t            wr_base,
    input  rel_pos_t         a_addr,
    output base_t            a_base,
    input  stripe_t          b_row,
    output logic [ROW_W-1:0] b_data
);

    base_t            a_mem [SEQ_LEN];
    logic [ROW_W-1:0] b_mem [N_STRIPE];

    // Contents are deliberately not reset; the host reloads before every run.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_sel)
            a_mem[wr_addr] <= wr_base;
        if (wr_en && wr_sel)
            b_mem[wr_addr[ADDR_W-1:6]][{wr_addr[5:0], 1'b0} +: 2] <= wr_base;
    end

    assign a_base = a_mem[a_addr];
    assign b_data = b_mem[b_row];

endmodule

// File: rtl/stripe_feeder.sv
// Sequencer feeding PE_array_64: one B stripe in parallel, A streamed serially
// from the accumulated start, per-stripe result capture and trace-back wait.
module stripe_feeder
    import feeder_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load_valid,
    input  logic                 i_load_sel,
    input  logic [ADDR_W-1:0]    i_load_addr,
    input  logic [1:0]           i_load_base,
    input  logic                 i_go,
    input  logic                 i_stripe_end,
    input  logic [ADDR_W-1:0]    i_start_position,
    input  logic [ADDR_W-1:0]    i_end_position,
    input  logic [SCORE_W-1:0]   i_max_score,
    output logic                 o_pe_start,
    output logic [2*N_PE-1:0]    o_pe_B,
    output logic [1:0]           o_pe_A,
    output logic                 o_busy,
    output logic                 o_result_valid,
    output logic [STRIPE_W-1:0]  o_stripe_idx,
    output logic [ABS_W-1:0]     o_abs_end,
    output logic [SCORE_W-1:0]   o_max_score,
    output logic                 o_done,
    output logic                 o_error
);

    state_t           state;
    stripe_t          k;
    abs_pos_t         start_acc;
    ptr_t             ptr;
    base_t            a_rd;
    logic [ROW_W-1:0] b_rd;
    logic             load_en;
    logic             in_range;
    ptr_t             ptr_next;
    ptr_t             drained;

    // Start positions only ever grow; clamp rather than wrap past 2047.
    function automatic abs_pos_t sat_add(input abs_pos_t acc, input rel_pos_t inc);
        logic [ABS_W:0] sum;
        sum = {1'b0, acc} + {2'b00, inc};
        return sum[ABS_W] ? '1 : sum[ABS_W-1:0];
    endfunction

    assign load_en  = i_load_valid && (state == S_IDLE);
    assign in_range = ptr < SEQ_END;
    assign ptr_next = ptr + ptr_t'(1);
    assign drained  = ptr_next - ptr_t'(start_acc);

    gene_buffer u_buf (
        .clk     (i_clk),
        .wr_en   (load_en),
        .wr_sel  (i_load_sel),
        .wr_addr (i_load_addr),
        .wr_base (i_load_base),
        .a_addr  (ptr[ADDR_W-1:0]),
        .a_base  (a_rd),
        .b_row   (k),
        .b_data  (b_rd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            k              <= '0;
            start_acc      <= '0;
            ptr            <= '0;
            o_pe_start     <= 1'b0;
            o_pe_B         <= '0;
            o_pe_A         <= '0;
            o_busy         <= 1'b0;
            o_result_valid <= 1'b0;
            o_stripe_idx   <= '0;
            o_abs_end      <= '0;
            o_max_score    <= '0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_result_valid <= 1'b0;
            o_done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_go) begin
                        o_error   <= 1'b0;
                        k         <= '0;
                        start_acc <= '0;
                        o_busy    <= 1'b1;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    o_pe_B     <= b_rd;
                    o_pe_start <= 1'b0;
                    o_pe_A     <= '0;
                    ptr        <= ptr_t'(start_acc);
                    state      <= S_STREAM;
                end
                S_STREAM: begin
                    if (i_stripe_end) begin
                        o_result_valid <= 1'b1;
                        o_stripe_idx   <= k;
                        o_abs_end      <= start_acc + abs_pos_t'(i_end_position);
                        o_max_score    <= i_max_score;
                        start_acc      <= sat_add(start_acc, i_start_position);
                        o_pe_start     <= 1'b0;
                        o_pe_A         <= '0;
                        if (k == LAST_STRIPE) begin
                            state <= S_TRACE_WAIT_LO;
                        end else begin
                            k     <= k + stripe_t'(1);
                            state <= S_SETUP;
                        end
                    end else begin
                        // Past the end of A the array still needs clock cycles to drain.
                        o_pe_start <= in_range;
                        o_pe_A     <= in_range ? a_rd : '0;
                        ptr        <= ptr_next;
                        if (drained == WDOG_LIMIT) begin
                            o_error    <= 1'b1;
                            o_pe_start <= 1'b0;
                            o_busy     <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_TRACE_WAIT_LO: begin
                    if (!i_stripe_end)
                        state <= S_TRACE_WAIT_HI;
                end
                S_TRACE_WAIT_HI: begin
                    if (i_stripe_end) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
